// File: rtl/frame_tracker.sv
// frame_tracker
//   Counts vertical-sync falling edges after a ROM download finishes and opens
//   a "dump window" starting at a chosen frame number for a chosen number of
//   frames (0 = never closes).
//
// Ports
//   clk        in   system clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   VGA_VS     in   vertical sync (same clock domain), active-high pulse
//   led        in   ROM download in progress; forces the tracker back to idle
//   frame_cnt  out  [31:0] VS falling edges counted since the download ended
//   vs_fall    out  one-cycle pulse per detected VS falling edge
//   dump_start out  one-cycle pulse on entry to the dump window
//   dump_en    out  high while the dump window is open
//   dump_done  out  sticky, high once a finite dump window has closed
module frame_tracker #(
    parameter logic [31:0] DUMP_START  = 32'd0,
    parameter logic [31:0] DUMP_FRAMES = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VGA_VS,
    input  logic        led,
    output logic [31:0] frame_cnt,
    output logic        vs_fall,
    output logic        dump_start,
    output logic        dump_en,
    output logic        dump_done
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_DUMP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        vs_l_q, vs_l_d;
    // vs_l resets to 1, which on its own would turn a VS that is already low
    // at reset release into a fake edge. vs_valid_q masks detection until
    // vs_l holds a real sample of VGA_VS.
    logic        vs_valid_q, vs_valid_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] win_cnt_q, win_cnt_d;
    logic        vs_fall_q, vs_fall_d;
    logic        dump_start_q, dump_start_d;
    logic        dump_en_q, dump_en_d;
    logic        dump_done_q, dump_done_d;
    logic        edge_det;

    assign edge_det = vs_valid_q & vs_l_q & ~VGA_VS;

    always_comb begin
        state_d      = state_q;
        vs_l_d       = VGA_VS;
        vs_valid_d   = 1'b1;
        frame_cnt_d  = frame_cnt_q;
        win_cnt_d    = win_cnt_q;
        vs_fall_d    = edge_det;
        dump_start_d = 1'b0;
        dump_en_d    = dump_en_q;
        dump_done_d  = dump_done_q;

        if (led) begin
            // download in progress wins over any simultaneous VS edge
            state_d     = S_WAIT;
            frame_cnt_d = 32'd0;
            win_cnt_d   = 32'd0;
            dump_en_d   = 1'b0;
            dump_done_d = 1'b0;
        end else begin
            case (state_q)
                // an edge in the exit cycle is deliberately not counted
                S_WAIT: state_d = S_COUNT;
                S_COUNT: begin
                    if (edge_det) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        if (frame_cnt_q == DUMP_START) begin
                            state_d      = S_DUMP;
                            win_cnt_d    = 32'd0;
                            dump_start_d = 1'b1;
                            dump_en_d    = 1'b1;
                        end
                    end
                end
                S_DUMP: begin
                    if (edge_det) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        win_cnt_d   = win_cnt_q + 32'd1;
                        if ((DUMP_FRAMES != 32'd0) && (win_cnt_q + 32'd1 == DUMP_FRAMES)) begin
                            state_d     = S_DONE;
                            dump_en_d   = 1'b0;
                            dump_done_d = 1'b1;
                        end
                    end
                end
                // DONE only counts; a wrapped frame_cnt never re-arms the window
                default: begin
                    if (edge_det)
                        frame_cnt_d = frame_cnt_q + 32'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT;
            vs_l_q       <= 1'b1;
            vs_valid_q   <= 1'b0;
            frame_cnt_q  <= 32'd0;
            win_cnt_q    <= 32'd0;
            vs_fall_q    <= 1'b0;
            dump_start_q <= 1'b0;
            dump_en_q    <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_l_q       <= vs_l_d;
            vs_valid_q   <= vs_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            win_cnt_q    <= win_cnt_d;
            vs_fall_q    <= vs_fall_d;
            dump_start_q <= dump_start_d;
            dump_en_q    <= dump_en_d;
            dump_done_q  <= dump_done_d;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign vs_fall    = vs_fall_q;
    assign dump_start = dump_start_q;
    assign dump_en    = dump_en_q;
    assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_frame_tracker.sv
// Bench for frame_tracker: two instances share stimulus, one with an
// unlimited window opening at frame 0 and one with a 2-frame window opening
// at frame 3. Expected outputs are pushed per VS falling edge and checked
// when the matching vs_fall pulse appears.
module tb_frame_tracker;

    logic clk = 1'b0;
    logic rst, VGA_VS, led;
    logic [31:0] fc0, fc1;
    logic vf0, vf1, ds0, ds1, de0, de1, dd0, dd1;

    always #5 clk = ~clk;

    frame_tracker #(.DUMP_START(32'd0), .DUMP_FRAMES(32'd0)) u0 (
        .clk(clk), .rst(rst), .VGA_VS(VGA_VS), .led(led),
        .frame_cnt(fc0), .vs_fall(vf0), .dump_start(ds0),
        .dump_en(de0), .dump_done(dd0)
    );

    frame_tracker #(.DUMP_START(32'd3), .DUMP_FRAMES(32'd2)) u1 (
        .clk(clk), .rst(rst), .VGA_VS(VGA_VS), .led(led),
        .frame_cnt(fc1), .vs_fall(vf1), .dump_start(ds1),
        .dump_en(de1), .dump_done(dd1)
    );

    typedef struct packed {
        logic [31:0] cnt;
        logic        start;
        logic        en;
        logic        done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int tests = 0;
    int fails = 0;

    // reference model, one slot per instance
    logic [31:0] mcnt[2];
    logic [31:0] mwin[2];
    int          mmode[2];     // 0 counting, 1 window open, 2 window closed
    logic [31:0] mst[2] = '{32'd0, 32'd3};
    logic [31:0] mfr[2] = '{32'd0, 32'd2};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 32'd0; mwin[i] = 32'd0; mmode[i] = 0;
        end
    endtask

    // counted = 0: a falling edge that must pulse vs_fall but not be counted
    task automatic model_edge(input bit counted);
        exp_t e;
        logic st;
        for (int i = 0; i < 2; i++) begin
            st = 1'b0;
            if (counted) begin
                if (mmode[i] == 0 && mcnt[i] == mst[i]) begin
                    mmode[i] = 1; mwin[i] = 32'd0; st = 1'b1;
                end else if (mmode[i] == 1) begin
                    mwin[i] = mwin[i] + 32'd1;
                    if (mfr[i] != 32'd0 && mwin[i] == mfr[i]) mmode[i] = 2;
                end
                mcnt[i] = mcnt[i] + 32'd1;
            end
            e.cnt = mcnt[i]; e.start = st; e.en = (mmode[i] == 1); e.done = (mmode[i] == 2);
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    // scoreboard monitor
    logic [1:0] vf_prev = 2'b00;
    always @(negedge clk) begin : mon
        exp_t e, got;
        logic [1:0] vf, ds;
        int qs;
        vf = {vf1, vf0};
        ds = {ds1, ds0};
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (ds[i] && !vf[i]) begin
                    fails++; $display("FAIL dump_start_alone u%0d: dump_start=1 vs_fall=0", i);
                end
                if (vf[i] && vf_prev[i]) begin
                    fails++; $display("FAIL vs_fall_twice u%0d: vs_fall high two cycles, required one", i);
                end
                if (vf[i]) begin
                    tests++;
                    qs = (i == 0) ? q0.size() : q1.size();
                    if (i == 0) got = {fc0, ds0, de0, dd0}; else got = {fc1, ds1, de1, dd1};
                    if (qs == 0) begin
                        fails++; $display("FAIL unexpected_vs_fall u%0d: got pulse cnt=%0d, required none", i, got.cnt);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        if (got !== e) begin
                            fails++;
                            $display("FAIL scoreboard u%0d: got cnt=%0d st=%b en=%b dn=%b, required cnt=%0d st=%b en=%b dn=%b",
                                     i, got.cnt, got.start, got.en, got.done, e.cnt, e.start, e.en, e.done);
                        end
                    end
                end
            end
        end
        vf_prev <= rst ? 2'b00 : vf;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_pulse(input int low_cycles);
        VGA_VS = 1'b1; cyc(3);
        VGA_VS = 1'b0; model_edge(1'b1);
        cyc(low_cycles);
    endtask

    task automatic drain_check(input string name);
        cyc(3);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL %s_missing_vs_fall: pending u0=%0d u1=%0d, required 0", name, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; VGA_VS = 1'b0; led = 1'b0;
        cyc(2);
        tests++;
        if ({fc0, vf0, ds0, de0, dd0} !== 36'd0 || {fc1, vf1, ds1, de1, dd1} !== 36'd0) begin
            fails++; $display("FAIL reset_outputs: u0 cnt=%0d flags=%b%b%b%b u1 cnt=%0d flags=%b%b%b%b, required all 0",
                              fc0, vf0, ds0, de0, dd0, fc1, vf1, ds1, de1, dd1);
        end
        model_reset();
        // release with VS already low: must not fake an edge
        rst = 1'b0;
        cyc(6);
        tests++;
        if (fc0 !== 32'd0 || fc1 !== 32'd0) begin
            fails++; $display("FAIL reset_release_count: got %0d/%0d, required 0/0", fc0, fc1);
        end
    endtask

    task automatic test_count_dump();
        for (int k = 0; k < 8; k++) vs_pulse(3);
        drain_check("count_dump");
        tests++;
        if (fc0 !== 32'd8 || de0 !== 1'b1 || dd0 !== 1'b0) begin
            fails++; $display("FAIL unlimited_window: cnt=%0d en=%b dn=%b, required 8 1 0", fc0, de0, dd0);
        end
        tests++;
        if (fc1 !== 32'd8 || de1 !== 1'b0 || dd1 !== 1'b1) begin
            fails++; $display("FAIL finite_window: cnt=%0d en=%b dn=%b, required 8 0 1", fc1, de1, dd1);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force u1.frame_cnt_q = 32'hFFFF_FFFE;
        #1 release u1.frame_cnt_q;
        mcnt[1] = 32'hFFFF_FFFE;
        cyc(2);
        for (int k = 0; k < 3; k++) vs_pulse(3);
        drain_check("wrap");
        tests++;
        if (fc1 !== 32'd1 || de1 !== 1'b0 || dd1 !== 1'b1) begin
            fails++; $display("FAIL wrap_done: cnt=%0d en=%b dn=%b, required 1 0 1", fc1, de1, dd1);
        end
    endtask

    task automatic test_led_clear();
        led = 1'b1;
        cyc(50);
        VGA_VS = 1'b1;
        cyc(50);
        tests++;
        if ({fc0, de0, dd0} !== 34'd0 || {fc1, de1, dd1} !== 34'd0) begin
            fails++; $display("FAIL led_clear: u0 cnt=%0d en=%b dn=%b u1 cnt=%0d en=%b dn=%b, required all 0",
                              fc0, de0, dd0, fc1, de1, dd1);
        end
        model_reset();
        // VS falls in the same cycle WAIT exits: pulse but no count
        led = 1'b0; VGA_VS = 1'b0; model_edge(1'b0);
        cyc(3);
        vs_pulse(3);
        vs_pulse(3);
        drain_check("led_clear");
        tests++;
        if (fc0 !== 32'd2 || de0 !== 1'b1 || fc1 !== 32'd2 || de1 !== 1'b0) begin
            fails++; $display("FAIL led_recount: cnt=%0d/%0d en=%b/%b, required 2/2 1/0", fc0, fc1, de0, de1);
        end
    endtask

    task automatic test_long_low_and_reset();
        vs_pulse(50);
        drain_check("long_low");
        VGA_VS = 1'b1; cyc(3);
        VGA_VS = 1'b0; model_edge(1'b1);
        cyc(3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({fc0, vf0, ds0, de0, dd0} !== 36'd0 || {fc1, vf1, ds1, de1, dd1} !== 36'd0) begin
            fails++; $display("FAIL async_reset: u0 cnt=%0d flags=%b%b%b%b u1 cnt=%0d flags=%b%b%b%b, required all 0",
                              fc0, vf0, ds0, de0, dd0, fc1, vf1, ds1, de1, dd1);
        end
        cyc(3);
        drain_check("pre_reset");
        model_reset();
        rst = 1'b0;
        cyc(10);
        vs_pulse(3);
        drain_check("post_reset");
        tests++;
        if (fc0 !== 32'd1 || de0 !== 1'b1 || fc1 !== 32'd1) begin
            fails++; $display("FAIL post_reset_count: cnt=%0d/%0d en0=%b, required 1/1 1", fc0, fc1, de0);
        end
    endtask

    initial begin
        test_reset();
        test_count_dump();
        test_wrap();
        test_led_clear();
        test_long_low_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
